mant_adder_arbiter: RTL

//  Shares one 48-bit carry-lookahead mantissa adder between two requesters:

---
 rtl/fp_alu_pkg.sv | 33 +++
 rtl/cla_tree_48bit.sv | 46 ++++
 rtl/mant_adder_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fp_alu_pkg.sv
// Shared definitions for the FP ALU mantissa datapath: widths, arbiter
// state encoding, requester port indices and 4-bit lookahead helpers.
package fp_alu_pkg;

  localparam int unsigned MANT_W    = 48;
  localparam int unsigned DEF_TAG_W = 4;

  typedef enum logic {
    ST_ARB,
    ST_LOCK
  } arb_state_e;

  localparam logic P_ADDSUB = 1'b0;
  localparam logic P_ROUND  = 1'b1;

  // Carries into positions 1..3 of a 4-wide lookahead group.
  function automatic logic [2:0] cla4_int(input logic [3:0] g,
                                          input logic [3:0] p,
                                          input logic       ci);
    cla4_int[0] = g[0] | (p[0] & ci);
    cla4_int[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    cla4_int[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
  endfunction

  // Group generate of a 4-wide lookahead group.
  function automatic logic cla4_gen(input logic [3:0] g,
                                    input logic [3:0] p);
    cla4_gen = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/cla_tree_48bit.sv
// 48-bit three-level carry-lookahead adder (4-bit groups, 16-bit
// supergroups, full lookahead across the three supergroups).
//  c_out : carry out of bit 47
//  s     : sum, modulo 2^48
//  a, b  : operands
//  c_in  : carry into bit 0
module cla_tree_48bit
  import fp_alu_pkg::*;
(
  output logic        c_out,
  output logic [47:0] s,
  input  logic [47:0] a,
  input  logic [47:0] b,
  input  logic        c_in
);

  logic [47:0] g, p, bc;
  logic [11:0] gg, gp, gc;
  logic [2:0]  sg_g, sg_p, sc;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < 12; k++) begin : g_grp
    assign gg[k] = cla4_gen(g[4*k +: 4], p[4*k +: 4]);
    assign gp[k] = &p[4*k +: 4];
    assign bc[4*k] = gc[k];
    assign bc[4*k+1 +: 3] = cla4_int(g[4*k +: 4], p[4*k +: 4], gc[k]);
  end

  for (genvar j = 0; j < 3; j++) begin : g_sgrp
    assign sg_g[j] = cla4_gen(gg[4*j +: 4], gp[4*j +: 4]);
    assign sg_p[j] = &gp[4*j +: 4];
    assign gc[4*j] = sc[j];
    assign gc[4*j+1 +: 3] = cla4_int(gg[4*j +: 4], gp[4*j +: 4], sc[j]);
  end

  assign sc[0] = c_in;
  assign sc[1] = sg_g[0] | (sg_p[0] & c_in);
  assign sc[2] = sg_g[1] | (sg_p[1] & sg_g[0]) | (sg_p[1] & sg_p[0] & c_in);
  assign c_out = sg_g[2] | (sg_p[2] & sg_g[1]) | (sg_p[2] & sg_p[1] & sg_g[0])
               | (&sg_p & c_in);

  assign s = p ^ bc;

endmodule

// File: rtl/mant_adder_arbiter.sv
// Shares one 48-bit CLA mantissa adder between the add/sub alignment path
// (port 0) and the round/normalise increment path (port 1).
// Round-robin arbitration, optional grant lock for multi-word chains with
// carry forwarding, subtraction by B inversion plus carry-in, and a single
// registered result buffer with valid/ready.
//  req_*      : per-port request, port p packed at [p*W +: W] / [p*TAG_W +: TAG_W]
//  req_ready  : per-port accept (transfer on valid & ready)
//  res_*      : registered result (sum, carry-out, issuing port, tag)
module mant_adder_arbiter
  import fp_alu_pkg::*;
#(
  parameter int unsigned W     = MANT_W,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*W-1:0]     req_a,
  input  logic [2*W-1:0]     req_b,
  input  logic [1:0]         req_sub,
  input  logic [1:0]         req_chain,
  input  logic [1:0]         req_lock,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W-1:0]       res_sum,
  output logic               res_cout,
  output logic               res_port,
  output logic [TAG_W-1:0]   res_tag
);

  arb_state_e       state_q, state_d;
  logic             lock_port_q, lock_port_d;
  logic             last_grant_q, last_grant_d;
  logic             carry_q, carry_d;
  logic             res_valid_q, res_valid_d;
  logic [W-1:0]     res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
  logic             res_port_q, res_port_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;

  logic             can_issue, grant, any_req, accept;
  logic [W-1:0]     op_a, op_b, b_eff, add_sum;
  logic             sel_sub, sel_chain, sel_lock, c_in, add_cout;
  logic [TAG_W-1:0] sel_tag;

  // A draining buffer frees its slot in the same cycle, so a new
  // request can be accepted while the old result is consumed.
  assign can_issue = !res_valid_q || res_ready;

  always_comb begin
    grant   = P_ADDSUB;
    any_req = 1'b0;
    if (state_q == ST_LOCK) begin
      grant   = lock_port_q;
      any_req = req_valid[lock_port_q];
    end else begin
      any_req = |req_valid;
      if (&req_valid) grant = ~last_grant_q;
      else            grant = req_valid[P_ROUND];
    end
  end

  assign req_ready[P_ADDSUB] = can_issue & (grant == P_ADDSUB);
  assign req_ready[P_ROUND]  = can_issue & (grant == P_ROUND);
  assign accept              = can_issue & any_req;

  assign op_a      = grant ? req_a[2*W-1:W] : req_a[W-1:0];
  assign op_b      = grant ? req_b[2*W-1:W] : req_b[W-1:0];
  assign sel_tag   = grant ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
  assign sel_sub   = req_sub[grant];
  assign sel_chain = req_chain[grant];
  assign sel_lock  = req_lock[grant];

  assign b_eff = sel_sub ? ~op_b : op_b;
  assign c_in  = sel_chain ? carry_q : sel_sub;

  cla_tree_48bit u_cla (
    .c_out (add_cout),
    .s     (add_sum),
    .a     (op_a),
    .b     (b_eff),
    .c_in  (c_in)
  );

  always_comb begin
    state_d      = state_q;
    lock_port_d  = lock_port_q;
    last_grant_d = last_grant_q;
    carry_d      = carry_q;
    res_valid_d  = res_valid_q;
    res_sum_d    = res_sum_q;
    res_cout_d   = res_cout_q;
    res_port_d   = res_port_q;
    res_tag_d    = res_tag_q;
    if (accept) begin
      last_grant_d = grant;
      carry_d      = add_cout;
      res_valid_d  = 1'b1;
      res_sum_d    = add_sum;
      res_cout_d   = add_cout;
      res_port_d   = grant;
      res_tag_d    = sel_tag;
      case (state_q)
        ST_ARB: begin
          if (sel_lock) begin
            state_d     = ST_LOCK;
            lock_port_d = grant;
          end
        end
        ST_LOCK: begin
          if (!sel_lock) state_d = ST_ARB;
        end
        default: state_d = ST_ARB;
      endcase
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      lock_port_q  <= P_ADDSUB;
      last_grant_q <= P_ROUND;
      carry_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_sum_q    <= '0;
      res_cout_q   <= 1'b0;
      res_port_q   <= 1'b0;
      res_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      lock_port_q  <= lock_port_d;
      last_grant_q <= last_grant_d;
      carry_q      <= carry_d;
      res_valid_q  <= res_valid_d;
      res_sum_q    <= res_sum_d;
      res_cout_q   <= res_cout_d;
      res_port_q   <= res_port_d;
      res_tag_q    <= res_tag_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_port  = res_port_q;
  assign res_tag   = res_tag_q;

endmodule
